stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Run/pause/clear sequencer for the seconds counter datapath; owns the 1 Hz prescaler.
//  Drives the counter's enable and reset inputs, extends time with a minutes count fed by
//  the counter's minute carry, and stops on minutes overflow. Sits between the button
//  front-end (debounced, single-cycle pulses) and the seconds counter.
// PARAMETERS
//  TICK_DIV  50_000_000  clk cycles per seconds tick; >= 2; prescaler width $clog2(TICK_DIV)
//  MAX_MIN   99          last valid minutes value; <= 127
// PORTS
//  clk         in   1  system clock; all logic on posedge
//  rst_n       in   1  synchronous, active-low reset
//  start_stop  in   1  1-cycle pulse: start / pause / resume
//  clear       in   1  1-cycle pulse: return to IDLE, zero all time
//  sec_carry   in   1  seconds counter carry (1-cycle pulse, registered, on 59->0 wrap)
//  cnt_enable  out  1  seconds counter enable; 1-cycle pulse per tick
//  cnt_reset   out  1  seconds counter synchronous clear; 1-cycle pulse
//  minutes     out  7  elapsed minutes, 0..MAX_MIN
//  running     out  1  1 while state == RUNNING
//  overflow    out  1  1 while state == OVF
// BEHAVIOUR
//  - All outputs registered. Reset (rst_n=0 at posedge): state IDLE, prescaler 0, minutes 0,
//    cnt_enable 0, cnt_reset 1 (clears counter alongside), running 0, overflow 0.
//  - States: IDLE, RUNNING, PAUSED, OVF. Transitions on start_stop:
//      IDLE->RUNNING, RUNNING->PAUSED, PAUSED->RUNNING; ignored in OVF.
//  - clear: any state -> IDLE; prescaler 0, minutes 0; cnt_reset=1 next cycle for 1 cycle.
//    clear wins over start_stop, sec_carry and tick in the same cycle.
//  - Prescaler: counts 0..TICK_DIV-1 only in RUNNING; held in PAUSED (fractional second
//    kept across pause); zeroed in IDLE/OVF. At terminal value in RUNNING: wraps to 0 and
//    cnt_enable=1 next cycle. First cnt_enable is high exactly TICK_DIV cycles after running rises.
//  - start_stop in RUNNING with prescaler at terminal: pause wins, no tick, prescaler holds
//    terminal; tick fires on the first RUNNING edge after resume.
//  - cnt_enable is never asserted outside RUNNING; cnt_enable and cnt_reset never both 1.
//  - sec_carry: accepted in RUNNING and PAUSED (carry lags enable by 1 cycle, so it can
//    land the cycle after a pause); ignored in IDLE and OVF.
//    minutes < MAX_MIN: minutes+1. minutes == MAX_MIN: -> OVF, minutes hold MAX_MIN
//    (counter reads 00 after its wrap); no further cnt_enable until clear.
//  - running/overflow track the state registered in the same edge.
// CONFIGURATION
//  STOPWATCH_LAP_EN defined: adds ports
//    lap in 1 (1-cycle pulse), seconds_in in 6 (counter value),
//    lap_min out 7, lap_sec out 6, lap_valid out 1.
//    lap in RUNNING or PAUSED: next cycle lap_min<=minutes, lap_sec<=seconds_in (values sampled
//    in the lap cycle), lap_valid<=1. Later laps overwrite. lap ignored in IDLE/OVF.
//    Reset and clear: lap_min/lap_sec 0, lap_valid 0; clear wins over lap.
//  Not defined: those ports and registers are absent; all other behaviour is identical.
// TESTING  (bench TICK_DIV=4, MAX_MIN=2)
//  - Reset: rst_n=0 for 2 cycles -> cnt_reset=1, running=0, minutes=0, overflow=0; then cnt_reset=0.
//  - start_stop pulse -> running=1 next cycle; cnt_enable pulses 4 cycles later, then every 4 cycles.
//  - Pause 2 cycles after a tick, hold 10 cycles, resume -> no cnt_enable while paused;
//    next cnt_enable 2 cycles after resume.
//  - sec_carry 1 cycle after pause -> minutes 0->1; sec_carry in IDLE -> minutes unchanged.
//  - Three sec_carry in RUNNING -> minutes 1,2 then overflow=1, running=0, minutes=2, no cnt_enable;
//    start_stop ignored; clear -> IDLE, minutes 0, cnt_reset 1-cycle pulse.
//  - clear and start_stop same cycle in RUNNING -> IDLE; with STOPWATCH_LAP_EN: lap at minutes=1,
//    seconds_in=37 -> lap_min=1, lap_sec=37, lap_valid=1; clear -> lap_valid=0.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/clear sequencer for the seconds counter.
// Owns the 1 Hz prescaler, counts minutes from the counter's minute carry
// and stops in OVF when minutes pass MAX_MIN.
// Optional lap capture is compiled in when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 50_000_000,
  parameter int MAX_MIN  = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       sec_carry,
`ifdef STOPWATCH_LAP_EN
  input  logic       lap,
  input  logic [5:0] seconds_in,
  output logic [6:0] lap_min,
  output logic [5:0] lap_sec,
  output logic       lap_valid,
`endif
  output logic       cnt_enable,
  output logic       cnt_reset,
  output logic [6:0] minutes,
  output logic       running,
  output logic       overflow
);

  localparam int            PW    = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TERM  = PW'(TICK_DIV - 1);
  localparam logic [6:0]    MAX_M = 7'(MAX_MIN);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    OVF     = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_nxt;
  logic [6:0]    min_nxt;
  logic          en_nxt;
  logic          carry_ok;
  logic          min_wrap;

  // A minute carry only counts while time is live (running or just paused);
  // at the last valid minute it pushes the stopwatch into OVF instead.
  assign carry_ok = sec_carry && ((state == RUNNING) || (state == PAUSED));
  assign min_wrap = carry_ok && (minutes == MAX_M);

  // State register plus all registered outputs; reset also clears the counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      presc      <= '0;
      minutes    <= '0;
      cnt_enable <= 1'b0;
      cnt_reset  <= 1'b1;
      running    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      presc      <= presc_nxt;
      minutes    <= min_nxt;
      cnt_enable <= en_nxt;
      cnt_reset  <= clear;
      running    <= (state_nxt == RUNNING);
      overflow   <= (state_nxt == OVF);
    end
  end

  // Next state: clear beats everything, overflow beats a pause/resume request.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_stop) state_nxt = RUNNING;
        RUNNING: begin
          if (min_wrap)        state_nxt = OVF;
          else if (start_stop) state_nxt = PAUSED;
        end
        PAUSED:  begin
          if (min_wrap)        state_nxt = OVF;
          else if (start_stop) state_nxt = RUNNING;
        end
        OVF:     state_nxt = OVF;
      endcase
    end
  end

  // Datapath next values: prescaler advances only on undisturbed RUNNING edges,
  // so a pause at the terminal count holds it and the tick lands after resume.
  always_comb begin
    presc_nxt = presc;
    min_nxt   = minutes;
    en_nxt    = 1'b0;
    if (clear) begin
      presc_nxt = '0;
      min_nxt   = '0;
    end else begin
      if (carry_ok && (minutes < MAX_M)) min_nxt = minutes + 7'd1;
      if ((state_nxt == IDLE) || (state_nxt == OVF)) begin
        presc_nxt = '0;
      end else if ((state == RUNNING) && !start_stop) begin
        if (presc == TERM) begin
          presc_nxt = '0;
          en_nxt    = 1'b1;
        end else begin
          presc_nxt = presc + 1'b1;
        end
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  // Lap capture: snapshot the live minutes/seconds; clear wipes the snapshot.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      lap_min   <= '0;
      lap_sec   <= '0;
      lap_valid <= 1'b0;
    end else if (lap && ((state == RUNNING) || (state == PAUSED))) begin
      lap_min   <= minutes;
      lap_sec   <= seconds_in;
      lap_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with TICK_DIV=4, MAX_MIN=2: directed vector table,
// hand-written reset/lap sequences, then random stimulus against a model.
module tb_stopwatch_ctrl;
  localparam int TICK_DIV = 4;
  localparam int MAX_MIN  = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_OVF = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       sec_carry = 1'b0;
  logic       cnt_enable;
  logic       cnt_reset;
  logic [6:0] minutes;
  logic       running;
  logic       overflow;
`ifdef STOPWATCH_LAP_EN
  logic       lap = 1'b0;
  logic [5:0] seconds_in = 6'd0;
  logic [6:0] lap_min;
  logic [5:0] lap_sec;
  logic       lap_valid;
`endif

  int total = 0;
  int bad   = 0;

  // reference model: mode, running cycles into the current second, minutes
  int m_mode = M_IDLE;
  int m_ph   = 0;
  int m_min  = 0;
  bit m_en   = 1'b0;
  bit m_rst  = 1'b1;

  typedef struct {
    bit ss, clr, car;
    bit run, en;
    int min;
    bit ovf, rst;
  } vec_t;
  vec_t tbl[$];

  stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .MAX_MIN(MAX_MIN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_stop (start_stop),
    .clear      (clear),
    .sec_carry  (sec_carry),
`ifdef STOPWATCH_LAP_EN
    .lap        (lap),
    .seconds_in (seconds_in),
    .lap_min    (lap_min),
    .lap_sec    (lap_sec),
    .lap_valid  (lap_valid),
`endif
    .cnt_enable (cnt_enable),
    .cnt_reset  (cnt_reset),
    .minutes    (minutes),
    .running    (running),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input bit ss, clr, car, run, en, input int min, input bit ovf, rst);
    vec_t v;
    v.ss = ss; v.clr = clr; v.car = car;
    v.run = run; v.en = en; v.min = min; v.ovf = ovf; v.rst = rst;
    tbl.push_back(v);
  endtask

  // Behavioural rules: a second elapses after TICK_DIV undisturbed running cycles.
  task automatic model_step(input bit ss, clr, car);
    bit live;
    m_en  = 1'b0;
    m_rst = clr;
    if (clr) begin
      m_mode = M_IDLE; m_ph = 0; m_min = 0;
    end else begin
      live = car && (m_mode == M_RUN || m_mode == M_PAUSE);
      if (live && m_min == MAX_MIN) begin
        m_mode = M_OVF; m_ph = 0;
      end else begin
        if (live) m_min = m_min + 1;
        if (m_mode == M_IDLE) begin
          if (ss) m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
          if (ss) m_mode = M_PAUSE;
          else begin
            m_ph = m_ph + 1;
            if (m_ph == TICK_DIV) begin m_ph = 0; m_en = 1'b1; end
          end
        end else if (m_mode == M_PAUSE) begin
          if (ss) m_mode = M_RUN;
        end
      end
    end
  endtask

  task automatic step(input bit ss, clr, car);
    @(negedge clk);
    start_stop = ss; clear = clr; sec_carry = car;
    @(posedge clk);
    if (!rst_n) begin
      m_mode = M_IDLE; m_ph = 0; m_min = 0; m_en = 1'b0; m_rst = 1'b1;
    end else begin
      model_step(ss, clr, car);
    end
    #1;
  endtask

  task automatic check_model(input int cyc);
    chk($sformatf("rnd%0d running", cyc), running, (m_mode == M_RUN));
    chk($sformatf("rnd%0d overflow", cyc), overflow, (m_mode == M_OVF));
    chk($sformatf("rnd%0d minutes", cyc), minutes, m_min);
    chk($sformatf("rnd%0d cnt_enable", cyc), cnt_enable, m_en);
    chk($sformatf("rnd%0d cnt_reset", cyc), cnt_reset, m_rst);
  endtask

  initial begin
    //   ss clr car | run en min ovf rst
    add(0, 0, 1,   0, 0, 0, 0, 0);   // carry in IDLE ignored
    add(1, 0, 0,   1, 0, 0, 0, 0);   // start
    add(0, 0, 0,   1, 0, 0, 0, 0);
    add(0, 0, 0,   1, 0, 0, 0, 0);
    add(0, 0, 0,   1, 0, 0, 0, 0);
    add(0, 0, 0,   1, 1, 0, 0, 0);   // first tick, 4 cycles after running
    add(0, 0, 0,   1, 0, 0, 0, 0);
    add(0, 0, 0,   1, 0, 0, 0, 0);
    add(1, 0, 0,   0, 0, 0, 0, 0);   // pause, two cycles into the second
    add(0, 0, 1,   0, 0, 1, 0, 0);   // carry right after pause
    for (int i = 0; i < 9; i++) add(0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0,   1, 0, 1, 0, 0);   // resume
    add(0, 0, 0,   1, 0, 1, 0, 0);
    add(0, 0, 0,   1, 1, 1, 0, 0);   // tick 2 cycles after resume
    add(0, 0, 0,   1, 0, 1, 0, 0);
    add(0, 0, 0,   1, 0, 1, 0, 0);
    add(0, 0, 0,   1, 0, 1, 0, 0);   // prescaler at terminal
    add(1, 0, 0,   0, 0, 1, 0, 0);   // pause wins over tick
    add(0, 0, 0,   0, 0, 1, 0, 0);
    add(1, 0, 0,   1, 0, 1, 0, 0);   // resume
    add(0, 0, 0,   1, 1, 1, 0, 0);   // held tick fires
    add(0, 0, 1,   1, 0, 2, 0, 0);   // minutes -> 2
    add(0, 0, 1,   0, 0, 2, 1, 0);   // overflow
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 2, 1, 0);
    add(1, 0, 0,   0, 0, 2, 1, 0);   // start_stop ignored in OVF
    add(0, 0, 1,   0, 0, 2, 1, 0);   // carry ignored in OVF
    add(0, 1, 0,   0, 0, 0, 0, 1);   // clear
    add(0, 0, 0,   0, 0, 0, 0, 0);
    add(1, 0, 0,   1, 0, 0, 0, 0);
    add(0, 0, 0,   1, 0, 0, 0, 0);
    add(1, 1, 0,   0, 0, 0, 0, 1);   // clear beats start_stop
    add(0, 0, 0,   0, 0, 0, 0, 0);
    add(1, 0, 0,   1, 0, 0, 0, 0);
    add(0, 0, 0,   1, 0, 0, 0, 0);
    add(0, 0, 0,   1, 0, 0, 0, 0);
    add(0, 0, 0,   1, 0, 0, 0, 0);
    add(0, 0, 0,   1, 1, 0, 0, 0);   // full second: clear zeroed the prescaler
    add(0, 0, 1,   1, 0, 1, 0, 0);
    add(0, 1, 1,   0, 0, 0, 0, 1);   // clear beats carry
    add(0, 0, 0,   0, 0, 0, 0, 0);

    // reset sequence
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0);
      chk($sformatf("reset%0d cnt_reset", i), cnt_reset, 1);
      chk($sformatf("reset%0d running", i), running, 0);
      chk($sformatf("reset%0d minutes", i), minutes, 0);
      chk($sformatf("reset%0d overflow", i), overflow, 0);
      chk($sformatf("reset%0d cnt_enable", i), cnt_enable, 0);
    end
    rst_n = 1'b1;
    step(0, 0, 0);
    chk("post_reset cnt_reset", cnt_reset, 0);
    chk("post_reset running", running, 0);

    // directed vector table
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].ss, tbl[i].clr, tbl[i].car);
      chk($sformatf("vec%0d running", i), running, tbl[i].run);
      chk($sformatf("vec%0d cnt_enable", i), cnt_enable, tbl[i].en);
      chk($sformatf("vec%0d minutes", i), minutes, tbl[i].min);
      chk($sformatf("vec%0d overflow", i), overflow, tbl[i].ovf);
      chk($sformatf("vec%0d cnt_reset", i), cnt_reset, tbl[i].rst);
    end

`ifdef STOPWATCH_LAP_EN
    // lap capture sequence
    step(1, 0, 0);
    step(0, 0, 1);
    lap = 1'b1; seconds_in = 6'd37;
    step(0, 0, 0);
    lap = 1'b0;
    chk("lap lap_min", lap_min, 1);
    chk("lap lap_sec", lap_sec, 37);
    chk("lap lap_valid", lap_valid, 1);
    seconds_in = 6'd12;
    step(0, 0, 0);
    chk("lap hold lap_sec", lap_sec, 37);
    lap = 1'b1;
    step(0, 1, 0);
    chk("lap clear lap_valid", lap_valid, 0);
    chk("lap clear lap_min", lap_min, 0);
    chk("lap clear lap_sec", lap_sec, 0);
    step(0, 0, 0);
    lap = 1'b0;
    chk("lap idle lap_valid", lap_valid, 0);
`endif

    // randomized stimulus against the model
    step(0, 1, 0);
    for (int c = 0; c < 800; c++) begin
      if (c == 400) rst_n = 1'b0;
      if (c == 402) rst_n = 1'b1;
      step(($urandom_range(0, 5) == 0), ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 6) == 0));
      check_model(c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
